// File: rtl/unpack.sv
// Packet receiver: hunts for the sync word in a 1-bit serial stream, regroups the
// fixed-length payload into output words and hands them out through a FWFT FIFO.
module unpack #(
    parameter int SIZE_BIT_PACK   = 1976,
    parameter int SIZE_INPUT_BIT  = 1,
    parameter int SIZE_OUTPUT_BIT = 8,
    parameter int SIZE_PREAMBLE   = 32,
    parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE = 32'h1ACFFC1D,
    parameter int MAX_ERR         = 0,
    parameter int FIFO_DEPTH      = 16,
    parameter int LENGTHE_PAYLOAD_WORD = (SIZE_BIT_PACK - SIZE_PREAMBLE) / SIZE_OUTPUT_BIT
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [SIZE_INPUT_BIT-1:0]  i_data,
    input  logic                       i_valid_input,
    output logic [SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                       o_valid,
    input  logic                       i_ready_output,
    output logic                       o_sync,
    output logic                       o_pack_done,
    output logic                       o_overflow
);

    localparam int BIT_CW  = (SIZE_OUTPUT_BIT > 1) ? $clog2(SIZE_OUTPUT_BIT) : 1;
    localparam int WORD_CW = $clog2(LENGTHE_PAYLOAD_WORD + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(SIZE_OUTPUT_BIT - 1);
    localparam logic [WORD_CW-1:0] WORD_LAST = WORD_CW'(LENGTHE_PAYLOAD_WORD - 1);
    localparam logic [AW:0]        FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    generate
        if ((SIZE_BIT_PACK - SIZE_PREAMBLE) % SIZE_OUTPUT_BIT != 0) begin : g_bad_len
            $error("payload length must be a whole number of output words");
        end
        if (SIZE_INPUT_BIT != 1) begin : g_bad_in
            $error("only a 1-bit serial input is supported");
        end
        if (SIZE_OUTPUT_BIT < 2 || SIZE_PREAMBLE < 2) begin : g_bad_w
            $error("output word and sync word must be at least 2 bits");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    typedef enum logic {HUNT, PAYLOAD} state_t;

    function automatic int err_count(input logic [SIZE_PREAMBLE-1:0] diff);
        int cnt;
        cnt = 0;
        for (int i = 0; i < SIZE_PREAMBLE; i++) begin
            if (diff[i]) cnt++;
        end
        return cnt;
    endfunction

    state_t                     state;
    logic [SIZE_PREAMBLE-1:0]   shreg;
    logic [SIZE_OUTPUT_BIT-1:0] word_reg;
    logic [BIT_CW-1:0]          bit_cnt;
    logic [WORD_CW-1:0]         word_cnt;

    logic [SIZE_PREAMBLE-1:0]   sh_next;
    logic [SIZE_OUTPUT_BIT-1:0] word_next;
    logic                       match;
    logic                       push;

    always_comb begin
        sh_next   = {shreg[SIZE_PREAMBLE-2:0], i_data[0]};
        word_next = {word_reg[SIZE_OUTPUT_BIT-2:0], i_data[0]};
        match     = err_count(sh_next ^ PREAMBLE) <= MAX_ERR;
        push      = (state == PAYLOAD) && i_valid_input && (bit_cnt == BIT_LAST);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= HUNT;
            shreg       <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            o_sync      <= 1'b0;
            o_pack_done <= 1'b0;
        end else begin
            o_pack_done <= 1'b0;
            if (i_valid_input) begin
                case (state)
                    HUNT: begin
                        shreg <= sh_next;
                        if (match) begin
                            state    <= PAYLOAD;
                            o_sync   <= 1'b1;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                        end
                    end
                    PAYLOAD: begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (word_cnt == WORD_LAST) begin
                                // Clearing the hunt register stops payload tails aliasing a sync word.
                                word_cnt    <= '0;
                                state       <= HUNT;
                                shreg       <= '0;
                                o_sync      <= 1'b0;
                                o_pack_done <= 1'b1;
                            end else begin
                                word_cnt <= word_cnt + WORD_CW'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CW'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == PAYLOAD && i_valid_input) word_reg <= word_next;
    end

    logic [SIZE_OUTPUT_BIT-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [AW:0]                count;
    logic                       full;
    logic                       empty;
    logic                       pop;
    logic                       wr_en;

    always_comb begin
        full  = (count == FULL_CNT);
        empty = (count == '0);
        pop   = i_ready_output && !empty;
        // A pop frees the slot in the same cycle, so a full FIFO can still take a word.
        wr_en = push && (!full || pop);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      count <= count + (AW + 1)'(1);
            else if (pop && !wr_en) count <= count - (AW + 1)'(1);
            if (push && !wr_en) o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= word_next;
    end

    assign o_valid = !empty;
    assign o_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_unpack.sv
// Directed bench for unpack: a default instance and a MAX_ERR=2 instance share the
// serial stream; expected words are queued as bytes are sent and popped on output.
module tb_unpack;

    localparam logic [31:0] PRE = 32'h1ACFFC1D;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       vin;
    logic       ready;
    logic [7:0] d0, d2;
    logic       v0, v2, s0, s2, pd0, pd2, of0, of2;

    int  checks = 0;
    int  errors = 0;
    int  done0  = 0;
    int  done2  = 0;
    bit  gap    = 1'b0;
    logic [7:0] q0[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    unpack dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_data(din), .i_valid_input(vin),
        .o_data(d0), .o_valid(v0), .i_ready_output(ready),
        .o_sync(s0), .o_pack_done(pd0), .o_overflow(of0)
    );

    unpack #(.MAX_ERR(2)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_data(din), .i_valid_input(vin),
        .o_data(d2), .o_valid(v2), .i_ready_output(ready),
        .o_sync(s2), .o_pack_done(pd2), .o_overflow(of2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output side: every accepted word must be the next one the bench queued.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pd0) done0++;
            if (pd2) done2++;
            if (v0 && ready) begin
                chk("dut0_word_expected", 32'(q0.size() > 0), 1);
                if (q0.size() > 0) chk("dut0_word", 32'(d0), 32'(q0.pop_front()));
            end
            if (v2 && ready) begin
                chk("dut2_word_expected", 32'(q2.size() > 0), 1);
                if (q2.size() > 0) chk("dut2_word", 32'(d2), 32'(q2.pop_front()));
            end
        end
    end

    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        din = b;
        vin = 1'b1;
        if (gap) begin
            @(posedge clk); #1;
            vin = 1'b0;
            din = 1'($urandom);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit p0, input bit p2);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        if (p0) q0.push_back(b);
        if (p2) q2.push_back(b);
    endtask

    task automatic send_pre(input logic [31:0] p);
        for (int i = 31; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            vin = 1'b0;
            din = 1'b0;
        end
    endtask

    task automatic send_packet(input logic [31:0] p, input bit p0, input bit p2);
        send_pre(p);
        for (int b = 0; b < 243; b++) send_byte(8'(b), p0, p2);
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 1'b0;
        vin   = 1'b0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(d0), 0);
        chk("rst_valid", 32'(v0), 0);
        chk("rst_sync", 32'(s0), 0);
        chk("rst_done", 32'(pd0), 0);
        chk("rst_overflow", 32'(of0), 0);
        rst_n = 1'b1;
        idle(2);

        // Noise without a sync word
        for (int i = 0; i < 500; i++) send_bit(1'($urandom));
        idle(2);
        chk("noise_sync", 32'(s0), 0);
        chk("noise_valid", 32'(v0), 0);
        chk("noise_done", 32'(done0), 0);
        chk("noise_sync_err2", 32'(s2), 0);

        // Clean packet, continuous valid
        send_pre(PRE);
        send_byte(8'h00, 1'b1, 1'b1);
        chk("clean_sync_high", 32'(s0), 1);
        for (int b = 1; b < 243; b++) send_byte(8'(b), 1'b1, 1'b1);
        idle(3);
        chk("clean_done", 32'(done0), 1);
        chk("clean_sync_low", 32'(s0), 0);
        chk("clean_overflow", 32'(of0), 0);
        chk("clean_drained", 32'(q0.size()), 0);
        chk("clean_done_err2", 32'(done2), 1);

        // Gapped valid, blank packet between two real ones
        gap = 1'b1;
        send_packet(PRE, 1'b1, 1'b1);
        for (int b = 0; b < 247; b++) send_byte(8'h55, 1'b0, 1'b0);
        send_packet(PRE, 1'b1, 1'b1);
        gap = 1'b0;
        idle(3);
        chk("gap_done", 32'(done0), 3);
        chk("gap_drained", 32'(q0.size()), 0);
        chk("gap_valid", 32'(v0), 0);
        chk("gap_drained_err2", 32'(q2.size()), 0);

        // Consumer stalled for a whole packet
        ready = 1'b0;
        send_pre(PRE);
        for (int b = 0; b < 243; b++) begin
            send_byte(8'(b), b < 16, b < 16);
            if (b == 16) chk("ovf_before_17th", 32'(of0), 0);
            if (b == 17) chk("ovf_after_17th", 32'(of0), 1);
        end
        idle(3);
        chk("stall_overflow", 32'(of0), 1);
        chk("stall_valid", 32'(v0), 1);
        chk("stall_head", 32'(d0), 0);
        chk("stall_queued", 32'(q0.size()), 16);
        chk("stall_overflow_err2", 32'(of2), 1);
        ready = 1'b1;
        idle(20);
        chk("stall_drained", 32'(q0.size()), 0);
        chk("stall_empty", 32'(v0), 0);
        chk("stall_sticky", 32'(of0), 1);
        chk("stall_done", 32'(done0), 4);

        // Reset at payload bit 100
        send_pre(PRE);
        for (int b = 0; b < 12; b++) send_byte(8'(b), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_data", 32'(d0), 0);
        chk("midrst_valid", 32'(v0), 0);
        chk("midrst_sync", 32'(s0), 0);
        chk("midrst_done", 32'(pd0), 0);
        chk("midrst_overflow", 32'(of0), 0);
        chk("midrst_sync_err2", 32'(s2), 0);
        chk("midrst_words_seen", 32'(q0.size()), 0);
        q0.delete();
        q2.delete();
        vin = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        send_packet(PRE, 1'b1, 1'b1);
        idle(3);
        chk("postrst_done", 32'(done0), 5);
        chk("postrst_drained", 32'(q0.size()), 0);
        chk("postrst_overflow", 32'(of0), 0);

        // Two flipped sync bits: only the tolerant instance locks
        send_pre(PRE ^ 32'h8000_0001);
        send_byte(8'h00, 1'b0, 1'b1);
        chk("flip2_sync_err0", 32'(s0), 0);
        chk("flip2_sync_err2", 32'(s2), 1);
        for (int b = 1; b < 243; b++) send_byte(8'(b), 1'b0, 1'b1);
        idle(3);
        chk("flip2_done_err0", 32'(done0), 5);
        chk("flip2_done_err2", 32'(done2), 6);
        chk("flip2_drained_err2", 32'(q2.size()), 0);

        // Three flipped sync bits: neither instance locks
        send_pre(PRE ^ 32'h8001_0001);
        send_byte(8'h00, 1'b0, 1'b0);
        chk("flip3_sync_err2", 32'(s2), 0);
        for (int b = 1; b < 243; b++) send_byte(8'h00, 1'b0, 1'b0);
        idle(3);
        chk("flip3_done_err2", 32'(done2), 6);
        chk("flip3_valid_err2", 32'(v2), 0);
        chk("flip3_valid_err0", 32'(v0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
